msrv32_branch_predict_unit: RTL and testbench
=============================================

# msrv32_branch_predict_unit

Parametrised branch resolution and prediction unit for the msrv32 core. It resolves RV32I control transfers (BEQ/BNE/BLT/BGE/BLTU/BGEU, JAL, JALR), with registered outputs. It keeps a direct-mapped table of 2-bit saturating counters indexed by PC to give a taken/not-taken prediction to the fetch stage. It also reports mispredictions and keeps saturating branch and mispredict statistics counters.

## Interface
- WIDTH, 32, operand and PC width.
- BHT_DEPTH, 64, number of 2-bit counters; power of two, >= 2.
- IDX_W, $clog2(BHT_DEPTH), table index width, derived.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- ms_riscv32_mp_clk_in  input  1  clock, all state updates on its rising edge.
- ms_riscv32_mp_rst_in  input  1  reset, synchronous, active-high.
- pred_valid_in  input  1  prediction lookup request.
- pred_pc_in  input  WIDTH  PC of the instruction being fetched.
- pred_valid_out  output  1  prediction result valid, one cycle after request.
- pred_taken_out  output  1  predicted direction.
- res_valid_in  input  1  resolve request from execute.
- res_pc_in  input  WIDTH  PC of the resolving instruction.
- rs1_in, rs2_in  input  WIDTH  source operands.
- opcode_6_to_2_in  input  5  instruction bits [6:2].
- funct3_in  input  3  instruction bits [14:12].
- res_pred_taken_in  input  1  prediction that was used for this instruction.
- res_valid_out  output  1  resolve result valid.
- branch_taken_out  output  1  actual direction.
- mispredict_out  output  1  actual direction differs from res_pred_taken_in.
- branch_count_out  output  CNT_WIDTH  resolved conditional branches, saturating.
- mispredict_count_out  output  CNT_WIDTH  conditional-branch mispredictions, saturating.

## Operation
- Index is pc[IDX_W+1:2] for both ports. Bits [1:0] are ignored.
- Counter encoding:
  - 00 = strong not-taken, 01 = weak not-taken, 10 = weak taken, 11 = strong taken.
  - Predicted taken = counter bit 1.
- Resolution (combinational in the requesting cycle, registered to the outputs):
  - Opcode 11000 (branch):
    - funct3 000: taken if rs1 == rs2.
    - 001: taken if rs1 != rs2.
    - 100: taken if signed rs1 < rs2.
    - 101: taken if signed rs1 >= rs2.
    - 110: taken if unsigned rs1 < rs2.
    - 111: taken if unsigned rs1 >= rs2.
    - 010/011: not taken, treated as non-control.
  - Opcode 11011 (JAL): always taken.
  - Opcode 11001 (JALR): taken when funct3 = 000, otherwise not taken. No latch-holding of the previous value.
  - Any other opcode: not taken.
- mispredict = taken XOR res_pred_taken_in, for every valid resolve.
- BHT update happens only for a valid conditional branch (opcode 11000, funct3 in {000, 001, 100, 101, 110, 111}):
  - Taken: increment, saturating at 11.
  - Not taken: decrement, saturating at 00.
- Statistics update only for the same valid conditional branches:
  - branch_count increments by 1 per branch.
  - mispredict_count increments by 1 when the branch mispredicted.
  - Both hold at all-ones.
- JAL, JALR and the non-control opcodes never touch the BHT or the counters.

## Timing
- Reset: all BHT entries = 01. Every output = 0, including both counters.
- Reset asserted mid-operation overrides any same-cycle request. Requests in the reset cycle are dropped.
- Prediction latency is 1 cycle:
  - pred_valid_out(t+1) = pred_valid_in(t).
  - pred_taken_out(t+1) = bit 1 of the entry at time t.
  - pred_taken_out = 0 whenever pred_valid_out = 0.
- Resolve latency is 1 cycle:
  - res_valid_out, branch_taken_out and mispredict_out are registered.
  - branch_taken_out and mispredict_out are 0 whenever res_valid_out = 0.
- The BHT write takes effect at the same edge that registers the resolve result.
- Simultaneous lookup and update to the same index in one cycle: the lookup returns the pre-update value (read-before-write).
- Back-to-back resolves to the same index accumulate: each cycle's update sees the previous cycle's write.
- Both ports are independent and accept a request every cycle. There is no stall or backpressure.

## Test plan
- Reset then lookup: pulse reset, lookup pc 0x0000_0040 -> pred_valid_out = 1, pred_taken_out = 0 one cycle later. branch_count_out = 0, mispredict_count_out = 0.
- Signed vs unsigned: rs1 = 0xFFFF_FFFF, rs2 = 0x0000_0001.
  - BLT (funct3 100) -> taken.
  - BLTU (110) -> not taken.
  - BGE (101) -> not taken.
  - BGEU (111) -> taken.
  - Each result is registered one cycle after res_valid_in.
- Saturation and training: three taken BEQ resolves (rs1 = rs2 = 5) at pc 0x100 -> entry goes 01→10→11→11.
  - Lookup of pc 0x100 then returns taken.
  - One not-taken resolve -> entry 10, still predicts taken.
- Aliasing with BHT_DEPTH = 64: train pc 0x100 taken -> lookup of pc 0x200 (same index 0) predicts taken.
- Same-cycle collision: entry at 01, resolve taken at pc 0x100 and lookup pc 0x100 in the same cycle.
  - Lookup returns not-taken.
  - The next lookup returns taken.
- Mispredict and counters:
  - JAL with res_pred_taken_in = 0 -> mispredict_out = 1, counters unchanged.
  - BNE with rs1 = rs2 and res_pred_taken_in = 1 -> mispredict_out = 1, branch_count +1, mispredict_count +1.
  - With CNT_WIDTH = 2, five branches -> branch_count_out holds at 3.

Source files
------------

// File: rtl/msrv32_branch_predict_unit.sv
// msrv32_branch_predict_unit: resolves RV32I branches/jumps and predicts direction from a 2-bit counter table
//   pred_valid_in/pred_pc_in -> pred_valid_out/pred_taken_out one cycle later
//   res_valid_in/res_pc_in/rs1_in/rs2_in/opcode_6_to_2_in/funct3_in/res_pred_taken_in
//     -> res_valid_out/branch_taken_out/mispredict_out one cycle later
//   branch_count_out/mispredict_count_out: saturating conditional-branch statistics
module msrv32_branch_predict_unit #(
  parameter int WIDTH     = 32,
  parameter int BHT_DEPTH = 64,
  parameter int IDX_W     = $clog2(BHT_DEPTH),
  parameter int CNT_WIDTH = 16
) (
  input  logic                 ms_riscv32_mp_clk_in,
  input  logic                 ms_riscv32_mp_rst_in,
  input  logic                 pred_valid_in,
  input  logic [WIDTH-1:0]     pred_pc_in,
  output logic                 pred_valid_out,
  output logic                 pred_taken_out,
  input  logic                 res_valid_in,
  input  logic [WIDTH-1:0]     res_pc_in,
  input  logic [WIDTH-1:0]     rs1_in,
  input  logic [WIDTH-1:0]     rs2_in,
  input  logic [4:0]           opcode_6_to_2_in,
  input  logic [2:0]           funct3_in,
  input  logic                 res_pred_taken_in,
  output logic                 res_valid_out,
  output logic                 branch_taken_out,
  output logic                 mispredict_out,
  output logic [CNT_WIDTH-1:0] branch_count_out,
  output logic [CNT_WIDTH-1:0] mispredict_count_out
);
  logic [1:0] bht_q [BHT_DEPTH];
  logic [1:0] bht_d [BHT_DEPTH];
  logic pred_valid_q, pred_valid_d, pred_taken_q, pred_taken_d;
  logic res_valid_q, res_valid_d, branch_taken_q, branch_taken_d, mispredict_q, mispredict_d;
  logic [CNT_WIDTH-1:0] branch_count_q, branch_count_d, mispredict_count_q, mispredict_count_d;
  logic [IDX_W-1:0] pred_idx, res_idx;
  logic [1:0] cur;
  logic is_br, cond, taken, mis, upd;
  logic unused_pc_bits;
  assign pred_idx = pred_pc_in[IDX_W+1:2];
  assign res_idx  = res_pc_in[IDX_W+1:2];
  assign unused_pc_bits = ^{pred_pc_in[WIDTH-1:IDX_W+2], pred_pc_in[1:0], res_pc_in[WIDTH-1:IDX_W+2], res_pc_in[1:0]};
  // funct3[2:1] picks the comparison, funct3[0] inverts it (BNE/BGE/BGEU)
  always_comb begin
    is_br = opcode_6_to_2_in == 5'b11000 && funct3_in[2:1] != 2'b01;
    cond  = funct3_in[2:1] == 2'b00 ? rs1_in == rs2_in :
            funct3_in[2:1] == 2'b10 ? $signed(rs1_in) < $signed(rs2_in) : rs1_in < rs2_in;
    taken = opcode_6_to_2_in == 5'b11000 ? is_br & (cond ^ funct3_in[0]) :
            opcode_6_to_2_in == 5'b11011 ? 1'b1 :
            opcode_6_to_2_in == 5'b11001 ? funct3_in == 3'b000 : 1'b0;
    mis   = taken ^ res_pred_taken_in;
    upd   = res_valid_in & is_br;
    cur   = bht_q[res_idx];
    bht_d = bht_q;
    if (upd) bht_d[res_idx] = taken ? (cur == 2'b11 ? cur : cur + 2'd1) : (cur == 2'b00 ? cur : cur - 2'd1);
    pred_valid_d       = pred_valid_in;
    pred_taken_d       = pred_valid_in & bht_q[pred_idx][1];
    res_valid_d        = res_valid_in;
    branch_taken_d     = res_valid_in & taken;
    mispredict_d       = res_valid_in & mis;
    branch_count_d     = upd && !(&branch_count_q) ? branch_count_q + CNT_WIDTH'(1) : branch_count_q;
    mispredict_count_d = upd && mis && !(&mispredict_count_q) ? mispredict_count_q + CNT_WIDTH'(1) : mispredict_count_q;
  end
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
      pred_valid_q       <= 1'b0;
      pred_taken_q       <= 1'b0;
      res_valid_q        <= 1'b0;
      branch_taken_q     <= 1'b0;
      mispredict_q       <= 1'b0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      bht_q              <= bht_d;
      pred_valid_q       <= pred_valid_d;
      pred_taken_q       <= pred_taken_d;
      res_valid_q        <= res_valid_d;
      branch_taken_q     <= branch_taken_d;
      mispredict_q       <= mispredict_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end
  assign pred_valid_out       = pred_valid_q;
  assign pred_taken_out       = pred_taken_q;
  assign res_valid_out        = res_valid_q;
  assign branch_taken_out     = branch_taken_q;
  assign mispredict_out       = mispredict_q;
  assign branch_count_out     = branch_count_q;
  assign mispredict_count_out = mispredict_count_q;
endmodule

// File: tb/tb_msrv32_branch_predict_unit.sv
// tb_msrv32_branch_predict_unit: directed self-checking bench for the branch predict unit
module tb_msrv32_branch_predict_unit;
  logic clk = 1'b0;
  logic rst, pred_valid_in, res_valid_in, res_pred_taken_in;
  logic [31:0] pred_pc_in, res_pc_in, rs1_in, rs2_in;
  logic [4:0] opcode_6_to_2_in;
  logic [2:0] funct3_in;
  logic pred_valid_out, pred_taken_out, res_valid_out, branch_taken_out, mispredict_out;
  logic [15:0] branch_count_out, mispredict_count_out;
  logic s_pred_valid_out, s_pred_taken_out, s_res_valid_out, s_branch_taken_out, s_mispredict_out;
  logic [1:0] s_branch_count_out, s_mispredict_count_out;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  msrv32_branch_predict_unit dut (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
    .pred_valid_in(pred_valid_in), .pred_pc_in(pred_pc_in),
    .pred_valid_out(pred_valid_out), .pred_taken_out(pred_taken_out),
    .res_valid_in(res_valid_in), .res_pc_in(res_pc_in), .rs1_in(rs1_in), .rs2_in(rs2_in),
    .opcode_6_to_2_in(opcode_6_to_2_in), .funct3_in(funct3_in), .res_pred_taken_in(res_pred_taken_in),
    .res_valid_out(res_valid_out), .branch_taken_out(branch_taken_out), .mispredict_out(mispredict_out),
    .branch_count_out(branch_count_out), .mispredict_count_out(mispredict_count_out)
  );
  msrv32_branch_predict_unit #(.CNT_WIDTH(2)) dut_sat (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
    .pred_valid_in(pred_valid_in), .pred_pc_in(pred_pc_in),
    .pred_valid_out(s_pred_valid_out), .pred_taken_out(s_pred_taken_out),
    .res_valid_in(res_valid_in), .res_pc_in(res_pc_in), .rs1_in(rs1_in), .rs2_in(rs2_in),
    .opcode_6_to_2_in(opcode_6_to_2_in), .funct3_in(funct3_in), .res_pred_taken_in(res_pred_taken_in),
    .res_valid_out(s_res_valid_out), .branch_taken_out(s_branch_taken_out), .mispredict_out(s_mispredict_out),
    .branch_count_out(s_branch_count_out), .mispredict_count_out(s_mispredict_count_out)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic idle();
    pred_valid_in = 1'b0;
    res_valid_in  = 1'b0;
  endtask
  task automatic res(input logic [4:0] op, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] pc, input logic pt);
    res_valid_in = 1'b1;
    opcode_6_to_2_in = op;
    funct3_in = f3;
    rs1_in = a;
    rs2_in = b;
    res_pc_in = pc;
    res_pred_taken_in = pt;
  endtask
  task automatic look(input logic [31:0] pc);
    pred_valid_in = 1'b1;
    pred_pc_in = pc;
  endtask
  task automatic chk_res(input string tag, input logic t, input logic m);
    chk({tag, " valid"}, {31'd0, res_valid_out}, 32'd1);
    chk({tag, " taken"}, {31'd0, branch_taken_out}, {31'd0, t});
    chk({tag, " mispredict"}, {31'd0, mispredict_out}, {31'd0, m});
  endtask
  task automatic chk_cnt(input string tag, input int b, input int m, input int sb, input int sm);
    chk({tag, " branch_count"}, {16'd0, branch_count_out}, b);
    chk({tag, " mispredict_count"}, {16'd0, mispredict_count_out}, m);
    chk({tag, " sat branch_count"}, {30'd0, s_branch_count_out}, sb);
    chk({tag, " sat mispredict_count"}, {30'd0, s_mispredict_count_out}, sm);
  endtask
  task automatic lookup_chk(input string tag, input logic [31:0] pc, input logic exp);
    idle();
    look(pc);
    step();
    chk({tag, " pred_valid"}, {31'd0, pred_valid_out}, 32'd1);
    chk({tag, " pred_taken"}, {31'd0, pred_taken_out}, {31'd0, exp});
  endtask
  logic [2:0] sf3 [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
  logic       stk [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  initial begin
    rst = 1'b1;
    idle();
    pred_pc_in = 32'h0; res_pc_in = 32'h0; rs1_in = 32'h0; rs2_in = 32'h0;
    opcode_6_to_2_in = 5'b0; funct3_in = 3'b0; res_pred_taken_in = 1'b0;
    @(negedge clk);
    look(32'h40);
    res(5'b11011, 3'b000, 0, 0, 32'h0, 1'b0);
    step();
    step();
    rst = 1'b0;
    chk("reset pred_valid", {31'd0, pred_valid_out}, 0);
    chk("reset pred_taken", {31'd0, pred_taken_out}, 0);
    chk("reset res_valid", {31'd0, res_valid_out}, 0);
    chk("reset branch_taken", {31'd0, branch_taken_out}, 0);
    chk("reset mispredict", {31'd0, mispredict_out}, 0);
    chk_cnt("reset", 0, 0, 0, 0);
    lookup_chk("lookup 0x40", 32'h40, 1'b0);
    chk_cnt("after lookup", 0, 0, 0, 0);
    idle();
    step();
    chk("idle pred_valid", {31'd0, pred_valid_out}, 0);
    chk("idle res_valid", {31'd0, res_valid_out}, 0);
    for (int i = 0; i < 4; i++) begin
      idle();
      res(5'b11000, sf3[i], 32'hFFFF_FFFF, 32'h1, 32'h40, 1'b0);
      step();
      chk_res($sformatf("signed f3=%0d", sf3[i]), stk[i], stk[i]);
    end
    chk_cnt("signed", 4, 2, 3, 2);
    idle();
    step();
    chk("idle taken", {31'd0, branch_taken_out}, 0);
    chk("idle mispredict", {31'd0, mispredict_out}, 0);
    res(5'b11000, 3'b000, 5, 5, 32'h100, 1'b1);
    look(32'h100);
    step();
    chk("collision pred_taken", {31'd0, pred_taken_out}, 0);
    chk_res("collision", 1'b1, 1'b0);
    lookup_chk("after collision", 32'h100, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle();
      res(5'b11000, 3'b000, 5, 5, 32'h100, 1'b1);
      step();
    end
    chk_res("train", 1'b1, 1'b0);
    lookup_chk("trained 0x100", 32'h100, 1'b1);
    lookup_chk("alias 0x200", 32'h200, 1'b1);
    idle();
    res(5'b11000, 3'b000, 5, 6, 32'h100, 1'b1);
    step();
    chk_res("beq not taken", 1'b0, 1'b1);
    lookup_chk("after one nt", 32'h100, 1'b1);
    idle();
    res(5'b11000, 3'b000, 5, 6, 32'h100, 1'b1);
    step();
    lookup_chk("after two nt", 32'h100, 1'b0);
    chk_cnt("training", 10, 4, 3, 3);
    idle();
    res(5'b11011, 3'b000, 0, 0, 32'h300, 1'b0);
    step();
    chk_res("jal", 1'b1, 1'b1);
    idle();
    res(5'b11001, 3'b000, 0, 0, 32'h300, 1'b1);
    step();
    chk_res("jalr f3=0", 1'b1, 1'b0);
    idle();
    res(5'b11001, 3'b001, 0, 0, 32'h300, 1'b1);
    step();
    chk_res("jalr f3=1", 1'b0, 1'b1);
    idle();
    res(5'b11000, 3'b010, 7, 7, 32'h300, 1'b0);
    step();
    chk_res("branch f3=2", 1'b0, 1'b0);
    idle();
    res(5'b00100, 3'b000, 7, 7, 32'h300, 1'b0);
    step();
    chk_res("alu op", 1'b0, 1'b0);
    chk_cnt("non-branch", 10, 4, 3, 3);
    lookup_chk("jumps leave bht", 32'h300, 1'b0);
    idle();
    res(5'b11000, 3'b001, 9, 9, 32'h80, 1'b1);
    step();
    chk_res("bne equal", 1'b0, 1'b1);
    chk_cnt("bne", 11, 5, 3, 3);
    idle();
    res(5'b11000, 3'b000, 1, 1, 32'h100, 1'b0);
    look(32'h100);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midreset pred_valid", {31'd0, pred_valid_out}, 0);
    chk("midreset res_valid", {31'd0, res_valid_out}, 0);
    chk_cnt("midreset", 0, 0, 0, 0);
    idle();
    res(5'b11000, 3'b000, 1, 1, 32'h100, 1'b0);
    step();
    chk_res("post reset beq", 1'b1, 1'b1);
    lookup_chk("post reset bht", 32'h100, 1'b1);
    idle();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
